// File: rtl/fifo_rd_drain.sv
// Drains a first-word-fall-through FIFO into a 2-entry buffer that feeds a valid/ready stream framed into BUR_LEN bursts.
// One cycle FIFO-to-stream; with m_ready low at most two words are popped before rinc stays low.
module fifo_rd_drain #(
  parameter int FIFO_WIDTH = 8,
  parameter int BUR_LEN    = 450,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [FIFO_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  enable,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  burst_cnt,
  output logic                  busy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] BEAT_MAX = CNT_WIDTH'(BUR_LEN - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [FIFO_WIDTH-1:0]   head;
  logic [FIFO_WIDTH-1:0]   tail;
  logic [CNT_WIDTH-1:0]    beat;
  logic                    pop_in;
  logic                    pop_out;
  logic                    last_beat;

  assign pop_in    = rinc;
  assign pop_out   = m_valid & m_ready;
  assign last_beat = (beat == BEAT_MAX);
  assign m_data    = head;
  assign m_last    = m_valid & last_beat;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) state <= EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (pop_in) state_nxt = ONE;
      ONE: begin
        if (pop_in && !pop_out)      state_nxt = TWO;
        else if (!pop_in && pop_out) state_nxt = EMPTY;
      end
      TWO:     if (pop_out) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // rinc is gated by rrst so nothing is popped while the buffer is held in reset.
  always_comb begin
    m_valid = (state != EMPTY);
    rinc    = enable & ~rempty & (state != TWO) & ~rrst;
    busy    = ~rrst & (m_valid | (enable & ~rempty));
  end

  // A new word goes to head when the buffer is (or is about to become) empty, else it queues in tail.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (pop_in && (state == EMPTY || pop_out)) head <= rdata;
      else if (pop_in)                           tail <= rdata;
      else if (state == TWO && pop_out)          head <= tail;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      beat      <= '0;
      word_cnt  <= '0;
      burst_cnt <= '0;
    end else if (pop_out) begin
      word_cnt <= word_cnt + CNT_ONE;
      if (last_beat) begin
        beat      <= '0;
        burst_cnt <= burst_cnt + CNT_ONE;
      end else begin
        beat <= beat + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: directed phases from the test plan plus a random phase, all checked against a word-queue model.
module tb_fifo_rd_drain;
  localparam int W  = 8;
  localparam int BL = 4;
  localparam int CW = 16;

  logic          rclk;
  logic          rrst;
  logic          rempty;
  logic [W-1:0]  rdata;
  logic          rinc;
  logic          enable;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] burst_cnt;
  logic          busy;

  fifo_rd_drain #(.FIFO_WIDTH(W), .BUR_LEN(BL), .CNT_WIDTH(CW)) dut (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .enable(enable), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .word_cnt(word_cnt), .burst_cnt(burst_cnt), .busy(busy)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Model: words still in the FIFO, words popped but not yet accepted, and accepted count.
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] buf_q[$];
  int mcnt;
  int total, bad;
  int pulses, nlast, first_last_idx, cyc, first_acc, last_acc, n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? '0 : fifo_q[0];
  endtask

  task automatic step();
    logic exp_rinc, pin, pout, has;
    drive_fifo();
    @(negedge rclk);
    has      = (buf_q.size() != 0);
    exp_rinc = enable && !rempty && (buf_q.size() < 2) && !rrst;
    chk("rinc", rinc, exp_rinc);
    chk("m_valid", m_valid, has);
    if (has) chk("m_data", m_data, buf_q[0]);
    if (rrst) chk("rst_m_data", m_data, 0);
    chk("m_last", m_last, has && (mcnt % BL == BL - 1));
    chk("word_cnt", word_cnt, mcnt[15:0]);
    chk("burst_cnt", burst_cnt, mcnt / BL);
    chk("busy", busy, !rrst && (has || (enable && !rempty)));
    pin  = exp_rinc;
    pout = has && m_ready;
    if (pout) begin
      if (m_last) begin
        nlast++;
        if (first_last_idx == 0) first_last_idx = mcnt + 1;
      end
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    @(posedge rclk);
    if (pout) begin
      void'(buf_q.pop_front());
      mcnt++;
    end
    if (pin) begin
      buf_q.push_back(fifo_q.pop_front());
      pulses++;
    end
    cyc++;
    #1;
    drive_fifo();
  endtask

  task automatic clear_stats();
    pulses = 0; nlast = 0; first_last_idx = 0; first_acc = -1; last_acc = -1;
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    buf_q.delete();
    mcnt = 0;
    step();
    step();
    rrst = 1'b0;
    clear_stats();
  endtask

  task automatic drain(input string tag);
    n = 0;
    while ((fifo_q.size() != 0 || buf_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk(tag, m_valid, 0);
  endtask

  task automatic fill_two(input string tag);
    n = 0;
    while (buf_q.size() < 2 && n < 50) begin
      step();
      n++;
    end
    chk(tag, m_valid && (n < 50), 1);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; mcnt = 0;
    rrst = 1'b1; enable = 1'b1; m_ready = 1'b1;
    clear_stats();
    for (int i = 1; i <= 16; i++) fifo_q.push_back(W'(2 * i));
    drive_fifo();

    // Reset with rempty=0 and enable=1: every output must hold at zero.
    do_reset();

    // Streaming 2..32 at full rate.
    drain("stream_drain");
    chk("stream_pulses", pulses, 16);
    chk("stream_word_cnt", word_cnt, 16);
    chk("stream_span", last_acc - first_acc, 15);
    chk("stream_busy", busy, 0);

    // Backpressure: 5 words, downstream stalled.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) fifo_q.push_back(W'(8'h50 + i));
    for (int i = 0; i < 6; i++) step();
    chk("bp_pulses", pulses, 2);
    chk("bp_head", m_data, 8'h50);
    m_ready = 1'b1;
    drain("bp_drain");
    chk("bp_pulses_all", pulses, 5);
    chk("bp_word_cnt", word_cnt, 5);

    // Bursts of 4 over 10 words, then two more to confirm beat resumed at 2.
    do_reset();
    for (int i = 0; i < 10; i++) fifo_q.push_back(W'(8'h80 + i));
    drain("burst_drain");
    chk("burst_lasts", nlast, 2);
    chk("burst_cnt10", burst_cnt, 2);
    chk("word_cnt10", word_cnt, 10);
    clear_stats();
    fifo_q.push_back(8'hA0);
    fifo_q.push_back(8'hA1);
    drain("burst_tail");
    chk("burst_next_last", first_last_idx, 12);

    // Enable drop while two words are buffered.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(W'(8'hC0 + i));
    fill_two("en_fill");
    enable = 1'b0;
    m_ready = 1'b1;
    clear_stats();
    for (int i = 0; i < 5; i++) step();
    chk("en_no_pop", pulses, 0);
    chk("en_drained", m_valid, 0);
    chk("en_busy", busy, 0);
    chk("en_word_cnt", word_cnt, 2);
    enable = 1'b1;
    drain("en_resume");

    // Reset mid-burst: beat=3 with two words held.
    do_reset();
    for (int i = 0; i < 10; i++) fifo_q.push_back(W'(8'hE0 + i));
    n = 0;
    while (mcnt < 3 && n < 50) begin
      step();
      n++;
    end
    m_ready = 1'b0;
    fill_two("mid_fill");
    #2 rrst = 1'b1;
    #1;
    chk("async_m_valid", m_valid, 0);
    chk("async_m_last", m_last, 0);
    chk("async_m_data", m_data, 0);
    chk("async_word_cnt", word_cnt, 0);
    chk("async_burst_cnt", burst_cnt, 0);
    chk("async_rinc", rinc, 0);
    chk("async_busy", busy, 0);
    buf_q.delete();
    mcnt = 0;
    step();
    rrst = 1'b0;
    m_ready = 1'b1;
    clear_stats();
    drain("mid_drain");
    chk("mid_first_last", first_last_idx, 4);

    // Random traffic, stalls and enable toggling.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 1) == 1) fifo_q.push_back(W'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      enable  = ($urandom_range(0, 7) != 0);
      step();
    end
    enable = 1'b1;
    m_ready = 1'b1;
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
